// File: rtl/udp_cmd_pkg.sv
// Shared constants and types for the system-clock register command path.
// The command bus arbiter's state enum and timeout read-back value live here.
package udp_cmd_pkg;

  localparam int MIB_ADDR_BITS               = 16;
  localparam int CMD_DATA_BITS               = 32;
  localparam int CMD_MASTER_ACK_TIMEOUT_CLKS = 64;

  // Read data returned to a master whose command timed out.
  localparam logic [CMD_DATA_BITS-1:0] CMD_ARB_ERR_RDATA = CMD_DATA_BITS'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } cmd_arb_state_t;

endpackage

// File: rtl/cmd_bus_arbiter_if.sv
// Command bus between the requesting masters, the arbiter and the register slave.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface cmd_bus_arbiter_if
  import udp_cmd_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_BITS = MIB_ADDR_BITS,
  parameter int DATA_BITS = CMD_DATA_BITS
);

  logic [NUM_REQ-1:0]           i_req_valid;
  logic [NUM_REQ-1:0]           i_req_rd_wr_n;
  logic [NUM_REQ*ADDR_BITS-1:0] i_req_addr;
  logic [NUM_REQ*DATA_BITS-1:0] i_req_wdata;
  logic [NUM_REQ-1:0]           o_req_ack;
  logic [DATA_BITS-1:0]         o_req_rdata;
  logic                         o_req_err;

  logic                         o_cmd_sel;
  logic                         o_cmd_rd_wr_n;
  logic [ADDR_BITS-1:0]         o_cmd_addr;
  logic [DATA_BITS-1:0]         o_cmd_wdata;
  logic                         i_cmd_ack;
  logic [DATA_BITS-1:0]         i_cmd_rdata;

  modport slave (
    input  i_req_valid, i_req_rd_wr_n, i_req_addr, i_req_wdata,
    input  i_cmd_ack, i_cmd_rdata,
    output o_req_ack, o_req_rdata, o_req_err,
    output o_cmd_sel, o_cmd_rd_wr_n, o_cmd_addr, o_cmd_wdata
  );

  modport master (
    output i_req_valid, i_req_rd_wr_n, i_req_addr, i_req_wdata,
    output i_cmd_ack, i_cmd_rdata,
    input  o_req_ack, o_req_rdata, o_req_err,
    input  o_cmd_sel, o_cmd_rd_wr_n, o_cmd_addr, o_cmd_wdata
  );

endinterface

// File: rtl/cmd_bus_arbiter_rr_arbiter.sv
// Combinational round-robin winner selection: searches from ptr+1 upward, wrapping.
// Produces a one-hot grant, its encoded index and an any-request flag.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int cand;

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/cmd_bus_arbiter.sv
// Round-robin arbiter sharing the single register command slave among NUM_REQ masters.
// Define CMD_BUS_ARB_TIMEOUT_EN to build the no-ack timeout counter and error response.
module cmd_bus_arbiter
  import udp_cmd_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_BITS    = MIB_ADDR_BITS,
  parameter int DATA_BITS    = CMD_DATA_BITS,
  parameter int TIMEOUT_CLKS = CMD_MASTER_ACK_TIMEOUT_CLKS
) (
  input  logic                       i_sys_clk,
  input  logic                       i_sys_srst_n,
  cmd_bus_arbiter_if.slave           bus,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_owner,
  output logic [7:0]                 stray_ack
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CLKS < 2) begin : g_param_check
    $error("cmd_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CLKS >= 2");
  end

  cmd_arb_state_t     state;
  logic [NUM_REQ-1:0] owner_oh;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;

  // The pointer is the owner register itself, so it only moves on a grant.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.i_req_valid),
    .ptr        (o_owner),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

`ifdef CMD_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CLKS);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments in this single clocked block.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_srst_n) begin
      state             <= IDLE;
      owner_oh          <= '0;
      o_owner           <= IDX_W'(NUM_REQ - 1);
      o_busy            <= 1'b0;
      stray_ack         <= '0;
      bus.o_req_ack     <= '0;
      bus.o_req_rdata   <= '0;
      bus.o_req_err     <= 1'b0;
      bus.o_cmd_sel     <= 1'b0;
      bus.o_cmd_rd_wr_n <= 1'b0;
      bus.o_cmd_addr    <= '0;
      bus.o_cmd_wdata   <= '0;
`ifdef CMD_BUS_ARB_TIMEOUT_EN
      tmo_cnt           <= '0;
`endif
    end else begin
      // Single-cycle pulses fall back to 0 unless the branch below raises them.
      bus.o_cmd_sel   <= 1'b0;
      bus.o_req_ack   <= '0;
      bus.o_req_rdata <= '0;
      bus.o_req_err   <= 1'b0;

      if (bus.i_cmd_ack && state != WAIT) begin
        stray_ack <= stray_ack + 8'd1;
      end

      case (state)
        IDLE: begin
          if (grant_valid) begin
            o_owner           <= grant_idx;
            owner_oh          <= grant;
            bus.o_cmd_rd_wr_n <= bus.i_req_rd_wr_n[grant_idx];
            bus.o_cmd_addr    <= bus.i_req_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
            bus.o_cmd_wdata   <= bus.i_req_wdata[grant_idx*DATA_BITS +: DATA_BITS];
            bus.o_cmd_sel     <= 1'b1;
            o_busy            <= 1'b1;
            state             <= ISSUE;
          end
        end

        ISSUE: begin
`ifdef CMD_BUS_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= WAIT;
        end

        WAIT: begin
          // An ack on the last counted cycle takes priority over the abort.
          if (bus.i_cmd_ack) begin
            bus.o_req_ack   <= owner_oh;
            bus.o_req_rdata <= bus.i_cmd_rdata;
            state           <= RESP;
          end
`ifdef CMD_BUS_ARB_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CLKS - 1)) begin
            bus.o_req_ack   <= owner_oh;
            bus.o_req_rdata <= DATA_BITS'(CMD_ARB_ERR_RDATA);
            bus.o_req_err   <= 1'b1;
            state           <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cmd_bus_arbiter.md
# cmd_bus_arbiter

Shares the single system-clock register command port (the `REGS_pio` command slave fed by `cmd_sys`) between several command masters: the MIB CDC path, the local UDP command path and on-chip sequencers. It grants one transaction at a time using round-robin arbitration and drives the selected request onto the slave port. It returns the read data and acknowledge to the owning master. An optional timeout recovers the bus when the slave never acknowledges.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters, 2..8.
- `ADDR_BITS`, `MIB_ADDR_BITS`: command address width.
- `DATA_BITS`, `CMD_DATA_BITS`: command data width.
- `TIMEOUT_CLKS`, `CMD_MASTER_ACK_TIMEOUT_CLKS`: number of WAIT cycles before abort. Must be ≥ 2.

Ports (clock and reset first):
- `i_sys_clk` in 1: the only clock. All logic is on its rising edge.
- `i_sys_srst_n` in 1: reset is synchronous and active-low.
- `i_req_valid` in NUM_REQ: per-requester request. Held high until the matching ack.
- `i_req_rd_wr_n` in NUM_REQ: 1 = read, 0 = write.
- `i_req_addr` in NUM_REQ*ADDR_BITS: packed. Requester r occupies slice [r*ADDR_BITS +: ADDR_BITS].
- `i_req_wdata` in NUM_REQ*DATA_BITS: packed, same slicing scheme.
- `o_req_ack` out NUM_REQ: one-cycle completion pulse to the owner.
- `o_req_rdata` out DATA_BITS: shared. Valid only while `o_req_ack` is high.
- `o_req_err` out 1: timeout flag. Valid only while `o_req_ack` is high.
- `o_cmd_sel` out 1: one-cycle strobe that issues the command to the slave.
- `o_cmd_rd_wr_n`, `o_cmd_addr`, `o_cmd_wdata` out 1/ADDR_BITS/DATA_BITS: slave command fields. Held stable from the `o_cmd_sel` cycle until the response.
- `i_cmd_ack` in 1: slave completion pulse.
- `i_cmd_rdata` in DATA_BITS: slave read data. Valid while `i_cmd_ack` is high.
- `o_busy` out 1: high in any state other than IDLE.
- `o_owner` out $clog2(NUM_REQ): index of the current or last granted requester.

## Operation
State machine:
- IDLE: if any `i_req_valid` bit is set, grant the round-robin winner. Latch its fields into the `o_cmd_*` outputs and go to ISSUE.
- ISSUE: `o_cmd_sel` = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - On `i_cmd_ack`: capture `i_cmd_rdata` (for writes as well) and go to RESP.
  - If the counter reaches TIMEOUT_CLKS-1 with no ack: go to RESP with the error flag set.
- RESP: `o_req_ack[owner]` = 1. `o_req_rdata` shows the captured data, or `CMD_ARB_ERR_RDATA` on timeout. `o_req_err` shows the flag. Go to IDLE.

Round-robin rules:
- The search starts at `o_owner`+1 and wraps modulo NUM_REQ.
- The pointer resets to NUM_REQ-1, so requester 0 has first priority after reset.
- The pointer updates only on a grant.

Boundary conditions:
- Valid bits that drop before they are granted are simply not granted. Withdrawing a granted request is illegal; the transaction still completes.
- An `i_cmd_ack` arriving in IDLE, ISSUE or RESP is ignored. It is counted in the `stray_ack` debug counter.
- If ack and timeout occur in the same cycle, the ack wins and `o_req_err` = 0.
- Reset taken mid-transaction:
  - Returns to IDLE and drops the transaction.
  - No `o_req_ack` is produced.
  - A late slave ack after reset counts as stray.

Reset values: all outputs are 0, except `o_owner` = NUM_REQ-1.

## Timing
- Timing is measured from `i_req_valid` first seen high in IDLE (cycle 0).
- `o_cmd_sel` is high in cycle 1.
- The earliest legal `i_cmd_ack` is in cycle 2. `o_req_ack` is then high in cycle 3, so minimum latency is 3.
- General case: a slave ack in cycle k produces `o_req_ack` in cycle k+1.
- A timeout abort produces `o_req_ack` in cycle 2+TIMEOUT_CLKS.
- Requesters drop or replace `i_req_valid` on the edge that ends the ack cycle. The next arbitration therefore sees the updated bits in cycle k+2.
- Back-to-back grants repeat every 4 cycles for a 1-cycle slave.
- All outputs are registered. There is no combinational path from input to output.

## Configuration
- Macro `CMD_BUS_ARB_TIMEOUT_EN`.
- Defined: the timeout counter and the error path described above are present.
- Undefined:
  - No counter is built.
  - WAIT waits indefinitely for `i_cmd_ack`.
  - `o_req_err` is tied to 0.
  - `CMD_ARB_ERR_RDATA` is unused.

## Structure
- Add `CMD_ARB_ERR_RDATA` (`DATA_BITS`'hDEAD_BEEF) and the `cmd_arb_state_t` enum (IDLE, ISSUE, WAIT, RESP) to `udp_cmd_pkg.sv`, next to `MIB_ADDR_BITS`, `CMD_DATA_BITS` and `CMD_MASTER_ACK_TIMEOUT_CLKS`.
- Sub-module `rr_arbiter`:
  - Combinational one-hot winner selection from `req` and the pointer, plus the encoded index.
  - Parameterised by NUM_REQ.
  - Reusable elsewhere.

## Test plan
- Single read from requester 1 at address 0x0040, slave acks in cycle 2 with 0x1234_5678 → `o_cmd_sel` in cycle 1, `o_req_ack` = 3'b010 in cycle 3, rdata 0x1234_5678, err = 0.
- All three requesters held valid, 1-cycle slave → grant order 0,1,2,0,… with grants 4 cycles apart. No requester is starved.
- With `CMD_BUS_ARB_TIMEOUT_EN`, TIMEOUT_CLKS = 16, slave silent → `o_req_ack` in cycle 18 with err = 1 and rdata 0xDEAD_BEEF. The next request is then serviced normally.
- Ack arriving on the final timeout cycle → err = 0 and the slave data is returned. A stray ack pulsed in IDLE → no `o_req_ack`, and `stray_ack` increments.
- `i_sys_srst_n` low during WAIT → all outputs 0 in the next cycle, no ack, `o_owner` = NUM_REQ-1. A slave ack arriving after reset is ignored.
- Write from requester 2 with wdata 0xA5A5_0001 → `o_cmd_rd_wr_n` = 0 and addr/wdata held stable from `o_cmd_sel` until ack. `o_req_ack` = 3'b100.
